// File: rtl/wb_bram_responder.sv
// wb_bram_responder
//   Wishbone slave block-RAM target. Serves classic single cycles and linear
//   incrementing bursts (CTI 010, terminated by 111 or any other CTI), with
//   a programmable number of wait states before the first ack of every
//   cycle/burst. Read data is registered and valid in the same cycle as ack.
//
// Parameters
//   adr_width   : word-address bits, depth = 2**adr_width 32-bit words
//   wait_states : extra cycles before the first ack (0..15)
//
// Ports
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   wb_adr_i   in   byte address, word index = wb_adr_i[adr_width+1:2]
//   wb_dat_i   in   write data
//   wb_dat_o   out  read data (meaningful only while wb_ack_o is high)
//   wb_cti_i   in   cycle type indicator
//   wb_sel_i   in   byte lane enables, bit 3 = [31:24]
//   wb_we_i    in   write enable
//   wb_cyc_i   in   bus cycle
//   wb_stb_i   in   strobe
//   wb_ack_o   out  acknowledge
module wb_bram_responder #(
  parameter int unsigned adr_width   = 10,
  parameter int unsigned wait_states = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [2:0]  wb_cti_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o
);

  localparam int unsigned DEPTH = 1 << adr_width;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_BURST
  } state_e;

  state_e               state_q;
  logic [adr_width-1:0] addr_q;
  logic [3:0]           wait_q;
  logic [31:0]          dat_q;

  logic [31:0] mem [DEPTH];

  logic                 req;
  logic                 beat;
  logic                 wr_en;
  logic [adr_width-1:0] idx;
  logic [adr_width-1:0] addr_inc;
  logic                 unused_adr;

  assign req      = wb_cyc_i & wb_stb_i;
  assign idx      = wb_adr_i[adr_width+1:2];
  assign addr_inc = addr_q + 1'b1;

  // Ack follows the registered state but is qualified by cyc&stb so that a
  // burst stall drops ack in the same cycle and resumes on the first cycle
  // the strobe returns.
  assign beat     = req & ((state_q == S_ACK) | (state_q == S_BURST));
  assign wb_ack_o = beat;
  assign wb_dat_o = dat_q;
  assign wr_en    = beat & wb_we_i;

  assign unused_adr = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};

  // dat_q is always loaded with the word of the next beat to be acked, so
  // consecutive ack cycles of a burst each carry the right data.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wait_q  <= '0;
      dat_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q <= idx;
            if (wait_states == 0) begin
              state_q <= S_ACK;
              dat_q   <= mem[idx];
            end else begin
              state_q <= S_WAIT;
              wait_q  <= 4'(wait_states - 1);
            end
          end
        end
        S_WAIT: begin
          if (!wb_cyc_i) begin
            state_q <= S_IDLE;
          end else if (wait_q == '0) begin
            state_q <= S_ACK;
            dat_q   <= mem[addr_q];
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        S_ACK, S_BURST: begin
          if (!wb_cyc_i) begin
            state_q <= S_IDLE;
          end else if (req) begin
            if (wb_cti_i == 3'b010) begin
              state_q <= S_BURST;
              addr_q  <= addr_inc;
              dat_q   <= mem[addr_inc];
            end else begin
              state_q <= S_IDLE;
            end
          end else if (state_q == S_ACK) begin
            state_q <= S_IDLE;
          end
          // stalled burst (cyc high, stb low): hold counter and data
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM contents are intentionally not reset.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) begin
          mem[addr_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: doc/wb_bram_responder.md
Name: wb_bram_responder

Overview:
- Wishbone slave endpoint behind the shared-bus arbiter/decoder.
- Block RAM target answering both classic single cycles and linear incrementing bursts (CTI-driven).
- Programmable initial wait states.
- Ack is registered, and read data is valid in the same cycle as ack. This matches the interconnect's registered read-data slave select.

Parameters:
- adr_width, 10: word-address bits; depth = 2^adr_width 32-bit words.
- wait_states, 0: extra cycles inserted before the first ack of any cycle/burst (0..15).

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- wb_adr_i  in  32  byte address; word index = wb_adr_i[adr_width+1:2], upper bits ignored
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst, others treated as 000
- wb_sel_i  in  4  byte lanes, bit 3 = [31:24]
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_ack_o  out  1  acknowledge

Behaviour:
- Reset (async, sys_rst_n=0): wb_ack_o=0, wb_dat_o=0, FSM=IDLE, wait counter=0, address counter=0. Ack clears immediately, not at the next edge. RAM contents are not reset.
- FSM states: IDLE, WAIT, ACK, BURST.
- IDLE:
  - On cyc&stb sampled at edge N, latch the word index into the address counter.
  - wait_states=0: go to ACK.
  - Otherwise: go to WAIT and load counter = wait_states-1.
- WAIT:
  - Decrement each cycle; at 0 go to ACK.
  - cyc low: go to IDLE.
- Ack latency: first ack is high in cycle N+1+wait_states.
- ACK (wb_ack_o=1 for exactly this cycle):
  - Write: RAM[counter] byte lanes per wb_sel_i take wb_dat_i at the end of this cycle.
  - Read: wb_dat_o = RAM[counter] during this cycle.
  - Next state:
    - wb_cti_i==010 and cyc&stb high: go to BURST and increment the counter.
    - Otherwise: go to IDLE, ack low next cycle. Classic cycles therefore always have a dead cycle between acks.
- BURST:
  - wb_ack_o = cyc&stb (no wait states within a burst).
  - Each acked beat writes or reads RAM[counter] as in ACK, then counter += 1.
  - Counter wraps modulo 2^adr_width (e.g. top word then word 0).
  - wb_adr_i is ignored after the first beat.
  - Read data for the next beat is prefetched so that every consecutive ack cycle carries correct data.
  - stb low with cyc high (master stall): ack low, counter holds, no write. Resume acking in the first cycle stb returns, with correct data.
  - An acked beat with cti==111 is the last: go to IDLE.
  - An acked beat with cti not 010/111 also ends the burst: go to IDLE.
  - cyc low at any time: go to IDLE next edge, ack low, no write.
- wb_dat_o outside ack cycles: holds its last value; contents undefined for the bench, checked only when ack=1.
- wb_we_i is sampled per acked beat; a mixed-direction burst is legal and handled beat by beat.
- The block must never raise ack when cyc or stb is low in the same cycle.

Test Plan:
- wait_states=0: classic write 0xDEADBEEF to byte addr 0x10, sel=1111; classic read addr 0x10. Required: each ack is a single-cycle pulse one cycle after stb; read returns 0xDEADBEEF.
- wait_states=3: classic write sel=0100 data 0x00AA0000 over prior 0x11223344, then read the same word. Required: ack 4 cycles after stb; read returns 0x11AA3344.
- wait_states=2: 4-beat burst read from word 8, cti=010,010,010,111, RAM[8..11]=1,2,3,4. Required:
  - first ack 3 cycles after stb;
  - then acks on 3 consecutive cycles;
  - data 1,2,3,4 in order;
  - ack low after the final beat.
- Burst write of 4 beats at word 2^adr_width-2 with master stb low for 2 cycles after beat 2. Required:
  - ack low during the stall;
  - writes land at top-1, top, 0, 1 (wrap);
  - no write during the stall;
  - read-back confirms.
- cyc dropped after beat 2 of an 8-beat burst write. Required: no further acks or writes; next classic read of word 0 acks normally with wait_states latency.
- sys_rst_n pulsed low mid-burst read. Required:
  - wb_ack_o and wb_dat_o go 0 asynchronously;
  - FSM in IDLE after release;
  - a subsequent classic cycle completes correctly;
  - RAM contents preserved.
